// File: rtl/adder_32.sv
// adder_32: 32-bit carry-lookahead adder with carry-out and signed overflow, plus registered copies.
// Latency: 0 cycles on the combinational outputs, 1 cycle on the *_reg outputs; no handshake or backpressure.

module adder_32_cla16 (
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_c,
    output logic [15:0] out_s,
    output logic        out_c
);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    always_comb begin
        g  = in_a & in_b;
        p  = in_a ^ in_b;
        gg = '0;
        gp = '0;
        c  = '0;
        gc = '0;

        // Group generate/propagate for each 4-bit group.
        for (int i = 0; i < 4; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            gp[i] = &p[4*i +: 4];
        end

        // Second-level lookahead: carry into each group from the block carry-in.
        gc[0] = in_c;
        gc[1] = gg[0] | (gp[0] & in_c);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & in_c);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & in_c);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & in_c);

        for (int i = 0; i < 4; i++) begin
            c[4*i]   = gc[i];
            c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
                     | (p[4*i+1] & p[4*i] & gc[i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                     | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
        end

        out_s = p ^ c;
        out_c = gc[4];
    end
endmodule

module adder_32 (
    input  logic        clk,
    input  logic        in_reset_n,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic        in_carry,
    output logic [31:0] out_sum,
    output logic        out_carry,
    output logic        out_overflow,
    output logic [31:0] out_sum_reg,
    output logic        out_carry_reg,
    output logic        out_overflow_reg
);
    logic        lo_carry;
    logic [31:0] sum_reg_d;
    logic [31:0] sum_reg_q;
    logic        carry_reg_d;
    logic        carry_reg_q;
    logic        overflow_reg_d;
    logic        overflow_reg_q;

    adder_32_cla16 u_lo (
        .in_a  (in_x[15:0]),
        .in_b  (in_y[15:0]),
        .in_c  (in_carry),
        .out_s (out_sum[15:0]),
        .out_c (lo_carry)
    );

    adder_32_cla16 u_hi (
        .in_a  (in_x[31:16]),
        .in_b  (in_y[31:16]),
        .in_c  (lo_carry),
        .out_s (out_sum[31:16]),
        .out_c (out_carry)
    );

    assign out_overflow = (in_x[31] == in_y[31]) && (out_sum[31] != in_x[31]);

    always_comb begin
        sum_reg_d      = out_sum;
        carry_reg_d    = out_carry;
        overflow_reg_d = out_overflow;
    end

    always_ff @(posedge clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            sum_reg_q      <= '0;
            carry_reg_q    <= 1'b0;
            overflow_reg_q <= 1'b0;
        end else begin
            sum_reg_q      <= sum_reg_d;
            carry_reg_q    <= carry_reg_d;
            overflow_reg_q <= overflow_reg_d;
        end
    end

    assign out_sum_reg      = sum_reg_q;
    assign out_carry_reg    = carry_reg_q;
    assign out_overflow_reg = overflow_reg_q;
endmodule

// File: tb/tb_adder_32.sv
// Self-checking bench for adder_32: directed corner cases, reset behaviour and a random sweep.
// Expected results are queued when stimulus is applied and popped when the registered outputs appear.

module tb_adder_32;
    logic        clk;
    logic        in_reset_n;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        in_carry;
    logic [31:0] out_sum;
    logic        out_carry;
    logic        out_overflow;
    logic [31:0] out_sum_reg;
    logic        out_carry_reg;
    logic        out_overflow_reg;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp;
    int   n_mis;

    adder_32 dut (
        .clk              (clk),
        .in_reset_n       (in_reset_n),
        .in_x             (in_x),
        .in_y             (in_y),
        .in_carry         (in_carry),
        .out_sum          (out_sum),
        .out_carry        (out_carry),
        .out_overflow     (out_overflow),
        .out_sum_reg      (out_sum_reg),
        .out_carry_reg    (out_carry_reg),
        .out_overflow_reg (out_overflow_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic ci);
        exp_t        e;
        logic [32:0] full;
        full    = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        e.sum   = full[31:0];
        e.carry = full[32];
        e.ovf   = (x[31] == y[31]) && (full[31] != x[31]);
        return e;
    endfunction

    task automatic pop_and_check_reg(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_sum_reg"}, {32'd0, out_sum_reg}, {32'd0, e.sum});
            check({tag, "_carry_reg"}, {63'd0, out_carry_reg}, {63'd0, e.carry});
            check({tag, "_ovf_reg"}, {63'd0, out_overflow_reg}, {63'd0, e.ovf});
        end
    endtask

    // Drive between edges, check the combinational result, then the registered copy one edge later.
    task automatic apply(input string tag, input logic [31:0] x, input logic [31:0] y, input logic ci);
        exp_t e;
        @(negedge clk);
        in_x     = x;
        in_y     = y;
        in_carry = ci;
        #1;
        e = model(x, y, ci);
        check({tag, "_sum"}, {32'd0, out_sum}, {32'd0, e.sum});
        check({tag, "_carry"}, {63'd0, out_carry}, {63'd0, e.carry});
        check({tag, "_ovf"}, {63'd0, out_overflow}, {63'd0, e.ovf});
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        pop_and_check_reg(tag);
    endtask

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        ci;
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } vec_t;

    vec_t dir_tbl[8];

    initial begin
        n_cmp      = 0;
        n_mis      = 0;
        in_reset_n = 1'b0;
        in_x       = 32'd0;
        in_y       = 32'd0;
        in_carry   = 1'b0;

        dir_tbl[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        dir_tbl[1] = '{32'hFFFFFFE1, 32'h00000000, 1'b1, 32'hFFFFFFE2, 1'b0, 1'b0};
        dir_tbl[2] = '{32'h000001F3, 32'h00000000, 1'b1, 32'h000001F4, 1'b0, 1'b0};
        dir_tbl[3] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
        dir_tbl[4] = '{32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0};
        dir_tbl[5] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        dir_tbl[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        dir_tbl[7] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};

        // Reset state, including across clock edges while held.
        #2;
        check("rst_sum_reg", {32'd0, out_sum_reg}, 64'd0);
        check("rst_carry_reg", {63'd0, out_carry_reg}, 64'd0);
        check("rst_ovf_reg", {63'd0, out_overflow_reg}, 64'd0);
        in_x = 32'h00000005;
        in_y = 32'h00000003;
        @(posedge clk);
        #1;
        check("rst_hold_sum_reg", {32'd0, out_sum_reg}, 64'd0);
        check("rst_comb_sum", {32'd0, out_sum}, 64'd8);
        @(negedge clk);
        in_reset_n = 1'b1;

        // Directed corner cases, also checked against hand-computed constants.
        for (int i = 0; i < 8; i++) begin
            apply($sformatf("dir%0d", i), dir_tbl[i].x, dir_tbl[i].y, dir_tbl[i].ci);
            check($sformatf("dir%0d_sum_const", i), {32'd0, out_sum}, {32'd0, dir_tbl[i].sum});
            check($sformatf("dir%0d_carry_const", i), {63'd0, out_carry}, {63'd0, dir_tbl[i].carry});
            check($sformatf("dir%0d_ovf_const", i), {63'd0, out_overflow}, {63'd0, dir_tbl[i].ovf});
        end

        // Reset asserted mid-cycle clears registers at once and leaves the combinational path alone.
        apply("pre_rst", 32'h12345670, 32'h00000008, 1'b0);
        check("pre_rst_sum_reg_const", {32'd0, out_sum_reg}, 64'h12345678);
        #2;
        in_reset_n = 1'b0;
        #1;
        check("mid_rst_sum_reg", {32'd0, out_sum_reg}, 64'd0);
        check("mid_rst_carry_reg", {63'd0, out_carry_reg}, 64'd0);
        check("mid_rst_ovf_reg", {63'd0, out_overflow_reg}, 64'd0);
        check("mid_rst_comb_sum", {32'd0, out_sum}, 64'h12345678);
        @(negedge clk);
        in_reset_n = 1'b1;
        #1;
        check("rel_rst_sum_reg", {32'd0, out_sum_reg}, 64'd0);
        sb_q.push_back(model(32'h12345670, 32'h00000008, 1'b0));
        @(posedge clk);
        #1;
        pop_and_check_reg("post_rst");
        check("post_rst_sum_reg_const", {32'd0, out_sum_reg}, 64'h12345678);

        // Random sweep.
        for (int i = 0; i < 10000; i++) begin
            apply("rnd", $urandom, $urandom, 1'($urandom_range(1, 0)));
        end

        check("sb_drained", {32'd0, 32'(sb_q.size())}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
